// File: rtl/hps_cmd_decoder_pkg.sv
// Shared types for the HPS command decoder: software opcodes, FSM states and
// the opcode offset that maps ALG opcodes onto engine operation codes.
package hps_cmd_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_WRITE = 3'd1,
        OP_READ  = 3'd2,
        OP_ALG0  = 3'd3,
        OP_ALG1  = 3'd4,
        OP_ALG2  = 3'd5,
        OP_ALG3  = 3'd6,
        OP_CLEAR = 3'd7
    } opcode_e;

    // Seven named states in a 3-bit encoding; the spare code is recovered to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_RD     = 3'd2,
        ST_AST    = 3'd3,
        ST_AWAIT  = 3'd4,
        ST_FINISH = 3'd5,
        ST_FAIL   = 3'd6
    } state_e;

    localparam logic [2:0] ALG_BASE = 3'd3;

endpackage

// File: rtl/hps_cmd_decoder.sv
// HPS PIO command decoder: turns edge-strobed software commands into RAM
// strobes or an engine start/wait handshake, with sticky status back to the HPS.
module hps_cmd_decoder
    import hps_cmd_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 8,
    parameter int MEM_DEPTH   = 76800,
    parameter int RD_LATENCY  = 2,
    parameter int ALG_TIMEOUT = 2000000
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [2:0]        pio_instruction,
    input  logic [DATA_W-1:0] pio_data,
    input  logic [ADDR_W-1:0] pio_mem_addr,
    input  logic              pio_sel_mem,
    input  logic              pio_enable,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_sel,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              alg_start,
    output logic [1:0]        alg_code,
    input  logic              alg_busy,
    input  logic              alg_done,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] rd_data
);

    localparam int               CNT_W     = $clog2(ALG_TIMEOUT);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_LATENCY);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(ALG_TIMEOUT - 1);
    localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              en_q;
    logic              cmd_edge;
    logic              addr_bad;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_sel_q, mem_sel_d;
    logic              alg_start_q, alg_start_d;
    logic [1:0]        alg_code_q, alg_code_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    assign cmd_edge = pio_enable & ~en_q;
    assign addr_bad = {1'b0, pio_mem_addr} >= DEPTH_LIM;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_wr_en_d = 1'b0;
        mem_rd_en_d = 1'b0;
        alg_start_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_sel_d   = mem_sel_q;
        alg_code_d  = alg_code_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        rd_data_d   = rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_edge) begin
                    mem_addr_d  = pio_mem_addr;
                    mem_wdata_d = pio_data;
                    mem_sel_d   = pio_sel_mem;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    case (opcode_e'(pio_instruction))
                        OP_NOP: state_d = ST_FINISH;
                        OP_WRITE: begin
                            if (addr_bad) begin
                                state_d = ST_FAIL;
                            end else begin
                                state_d     = ST_WR;
                                mem_wr_en_d = 1'b1;
                            end
                        end
                        OP_READ: begin
                            if (addr_bad) begin
                                state_d = ST_FAIL;
                            end else begin
                                state_d     = ST_RD;
                                mem_rd_en_d = 1'b1;
                                cnt_d       = '0;
                            end
                        end
                        OP_CLEAR: begin
                            rd_data_d = '0;
                            state_d   = ST_FINISH;
                        end
                        default: begin
                            alg_code_d = 2'(pio_instruction - ALG_BASE);
                            if (alg_busy) begin
                                state_d = ST_FAIL;
                            end else begin
                                state_d     = ST_AST;
                                alg_start_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_WR: state_d = ST_FINISH;
            ST_RD: begin
                if (cnt_q == RD_LAST) begin
                    rd_data_d = mem_rdata;
                    state_d   = ST_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_AST: begin
                cnt_d   = '0;
                state_d = ST_AWAIT;
            end
            // A done pulse wins over a timeout landing in the same cycle.
            ST_AWAIT: begin
                if (alg_done) begin
                    state_d = ST_FINISH;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_FAIL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            ST_FAIL:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Status is registered with the transition so it is visible in FINISH/FAIL.
        case (state_d)
            ST_FINISH: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            ST_FAIL: begin
                done_d  = 1'b1;
                error_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: ;
        endcase

        if (cmd_edge && (state_q != ST_IDLE)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            en_q        <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_sel_q   <= 1'b0;
            alg_start_q <= 1'b0;
            alg_code_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_q        <= pio_enable;
            mem_wr_en_q <= mem_wr_en_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_sel_q   <= mem_sel_d;
            alg_start_q <= alg_start_d;
            alg_code_q  <= alg_code_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign mem_wr_en = mem_wr_en_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_sel   = mem_sel_q;
    assign alg_start = alg_start_q;
    assign alg_code  = alg_code_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_hps_cmd_decoder.sv
// Bench for hps_cmd_decoder: directed and random commands against a
// command-level outcome model, with a latency-accurate RAM and engine model.
module tb_hps_cmd_decoder;

    localparam int ADDR_W      = 17;
    localparam int DATA_W      = 8;
    localparam int MEM_DEPTH   = 76800;
    localparam int RD_LATENCY  = 2;
    localparam int ALG_TIMEOUT = 100;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        pio_instruction;
    logic [DATA_W-1:0] pio_data;
    logic [ADDR_W-1:0] pio_mem_addr;
    logic              pio_sel_mem;
    logic              pio_enable;
    logic              mem_wr_en, mem_rd_en, mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata, rd_data;
    logic              alg_start, alg_busy, alg_done;
    logic [1:0]        alg_code;
    logic              busy, done, error;

    int vectors     = 0;
    int miscompares = 0;
    int wrCount     = 0;
    int rdCount     = 0;
    int startCount  = 0;

    logic [7:0] ram        [0:262143];
    bit         ramValid   [0:262143];
    logic [7:0] shadow     [0:262143];
    bit         shadowValid[0:262143];
    logic [7:0] rdStage    [1:RD_LATENCY];
    logic [7:0] expRdData  = 8'h00;
    logic [1:0] expAlgCode = 2'd0;

    always #5 clk = ~clk;

    hps_cmd_decoder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH),
        .RD_LATENCY(RD_LATENCY), .ALG_TIMEOUT(ALG_TIMEOUT)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .pio_instruction(pio_instruction), .pio_data(pio_data),
        .pio_mem_addr(pio_mem_addr), .pio_sel_mem(pio_sel_mem), .pio_enable(pio_enable),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata),
        .alg_start(alg_start), .alg_code(alg_code), .alg_busy(alg_busy), .alg_done(alg_done),
        .busy(busy), .done(done), .error(error), .rd_data(rd_data)
    );

    function automatic logic [7:0] initByte(input int k);
        return k[7:0] ^ k[15:8] ^ 8'h5A;
    endfunction

    // RAM model: data appears RD_LATENCY cycles after the read strobe, garbage otherwise.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            wrCount <= wrCount + 1;
            ram[{mem_sel, mem_addr}]      <= mem_wdata;
            ramValid[{mem_sel, mem_addr}] <= 1'b1;
        end
        if (mem_rd_en) rdCount <= rdCount + 1;
        if (alg_start) startCount <= startCount + 1;
        rdStage[1] <= !mem_rd_en ? 8'hEE :
                      ramValid[{mem_sel, mem_addr}] ? ram[{mem_sel, mem_addr}] :
                      initByte(int'({mem_sel, mem_addr}));
        for (int i = 2; i <= RD_LATENCY; i++) rdStage[i] <= rdStage[i-1];
    end
    assign mem_rdata = rdStage[RD_LATENCY];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [16:0] addr,
                                 input logic [7:0] data, input logic sel);
        @(negedge clk);
        pio_instruction = op;
        pio_mem_addr    = addr;
        pio_data        = data;
        pio_sel_mem     = sel;
        pio_enable      = 1'b1;
        @(negedge clk);
        pio_enable      = 1'b0;
    endtask

    // Predicts the outcome of one command from the opcode rules, drives it and the engine.
    task automatic runCommand(input string name, input int op, input logic [16:0] addr,
                              input logic [7:0] data, input logic sel, input logic algBusy,
                              input int delay, input int intrudeAt);
        int  key, lat, w0, r0, s0;
        bit  valid, fail, expWr, expRd, expStart, hasDone, tracked, intruded, busyDrop;
        key = int'({sel, addr});
        valid = int'(addr) < MEM_DEPTH;
        fail = 0; expWr = 0; expRd = 0; expStart = 0; hasDone = 0; busyDrop = 0;
        lat = 2;
        if (op == 1) begin
            if (valid) begin
                expWr = 1;
                shadow[key] = data;
                shadowValid[key] = 1'b1;
            end else fail = 1;
        end else if (op == 2) begin
            if (valid) begin
                expRd = 1;
                lat = 2 + RD_LATENCY;
                expRdData = shadowValid[key] ? shadow[key] : initByte(key);
            end else fail = 1;
        end else if (op == 7) begin
            expRdData = 8'h00;
        end else if (op >= 3 && op <= 6) begin
            expAlgCode = 2'(op - 3);
            if (algBusy) fail = 1;
            else begin
                expStart = 1;
                if (delay >= 1 && delay <= ALG_TIMEOUT) begin
                    hasDone = 1;
                    lat = 2 + delay;
                end else begin
                    fail = 1;
                    lat = 2 + ALG_TIMEOUT;
                end
            end
        end
        tracked  = expWr | expRd | expStart;
        intruded = (intrudeAt > 0) && (intrudeAt + 1 < lat);
        w0 = wrCount; r0 = rdCount; s0 = startCount;

        alg_busy = algBusy;
        applyStimulus(3'(op), addr, data, sel);
        alg_busy = 1'b0;
        for (int c = 1; c < lat; c++) begin
            alg_done = hasDone && (c == 1 + delay);
            if (c == 1) begin
                if (expWr)    checkOutput({name, "_wr_strobe"}, mem_wr_en, 1);
                if (expRd)    checkOutput({name, "_rd_strobe"}, mem_rd_en, 1);
                if (expStart) checkOutput({name, "_alg_start"}, alg_start, 1);
            end
            if (tracked && busy !== 1'b1) busyDrop = 1;
            if (intruded && c == intrudeAt) begin
                pio_instruction = 3'd1;
                pio_mem_addr    = ~addr;
                pio_data        = ~data;
                pio_sel_mem     = ~sel;
                pio_enable      = 1'b1;
            end
            if (intruded && c == intrudeAt + 1) begin
                pio_enable = 1'b0;
                checkOutput({name, "_overrun_err"}, error, 1);
            end
            if (tracked && c == lat - 1) checkOutput({name, "_done_early"}, done, 0);
            @(negedge clk);
        end
        alg_done = 1'b0;
        if (tracked) checkOutput({name, "_busy_held"}, busyDrop, 0);
        checkOutput({name, "_done"},    done, 1);
        checkOutput({name, "_busy"},    busy, 0);
        checkOutput({name, "_error"},   error, fail | intruded);
        checkOutput({name, "_rd_data"}, rd_data, expRdData);
        checkOutput({name, "_strobes"}, {wrCount - w0, rdCount - r0, startCount - s0},
                    {32'(expWr), 32'(expRd), 32'(expStart)});
        checkOutput({name, "_mem_addr"}, {mem_sel, mem_wdata, mem_addr}, {sel, data, addr});
        if (expStart) checkOutput({name, "_alg_code"}, alg_code, expAlgCode);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int          op, delay, r0;
        logic [16:0] addr;
        rst_n = 1'b0;
        pio_instruction = 3'd0; pio_data = 8'h00; pio_mem_addr = '0;
        pio_sel_mem = 1'b0; pio_enable = 1'b0; alg_busy = 1'b0; alg_done = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_status", {busy, done, error, rd_data}, 0);
        checkOutput("reset_strobes", {mem_wr_en, mem_rd_en, alg_start, alg_code}, 0);
        checkOutput("reset_mem", {mem_sel, mem_wdata, mem_addr}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        runCommand("write", 1, 17'h00010, 8'hA5, 1'b1, 1'b0, -1, 0);
        runCommand("write_3c", 1, 17'h00123, 8'h3C, 1'b0, 1'b0, -1, 0);
        runCommand("read_3c", 2, 17'h00123, 8'h77, 1'b0, 1'b0, -1, 0);
        runCommand("write_oob", 1, 17'd76800, 8'h11, 1'b0, 1'b0, -1, 0);
        runCommand("nop", 0, 17'h00001, 8'h22, 1'b1, 1'b0, -1, 0);
        runCommand("write_last", 1, 17'd76799, 8'h99, 1'b1, 1'b0, -1, 0);
        runCommand("read_last", 2, 17'd76799, 8'h00, 1'b1, 1'b0, -1, 0);
        runCommand("read_oob", 2, 17'h1FFFF, 8'h00, 1'b1, 1'b0, -1, 0);
        runCommand("alg_op4", 4, 17'h00000, 8'h00, 1'b0, 1'b0, 50, 0);
        runCommand("alg_timeout", 5, 17'h00042, 8'h42, 1'b1, 1'b0, -1, 30);
        runCommand("alg_tie", 6, 17'h00005, 8'h05, 1'b0, 1'b0, ALG_TIMEOUT, 0);
        runCommand("alg_engbusy", 3, 17'h00006, 8'h06, 1'b0, 1'b1, 10, 0);
        runCommand("clear", 7, 17'h00007, 8'h07, 1'b0, 1'b0, -1, 0);

        // Enable held high across a READ that is cut short by reset.
        r0 = rdCount;
        @(negedge clk);
        pio_instruction = 3'd2; pio_mem_addr = 17'h00123; pio_sel_mem = 1'b0; pio_enable = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_status", {busy, done, error, rd_data}, 0);
        checkOutput("rst_mid_strobes", {mem_wr_en, mem_rd_en, alg_start, alg_code}, 0);
        checkOutput("rst_mid_mem", {mem_sel, mem_wdata, mem_addr}, 0);
        repeat (18) @(negedge clk);
        pio_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("rst_one_read", rdCount - r0, 1);
        checkOutput("rst_no_late", {busy, done, error, mem_rd_en}, 0);
        expRdData = 8'h00;

        for (int i = 0; i < 30; i++) begin
            op = int'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0)      addr = 17'($urandom_range(MEM_DEPTH, 131071));
            else if ($urandom_range(0, 1) == 0) addr = 17'($urandom_range(0, 15));
            else                                addr = 17'($urandom_range(0, MEM_DEPTH - 1));
            delay = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 40));
            runCommand("rand", op, addr, 8'($urandom), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0), delay, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
